// File: rtl/bist_if.sv
// Control/status bundle between the BIST sequencer and the test controller / BIST datapath.
// The abort signal exists only when BIST_ABORT_EN is defined.
interface bist_if #(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [SIG_W-1:0] sig;
`ifdef BIST_ABORT_EN
  logic             abort;
`endif
  logic             lfsr_load;
  logic             lfsr_en;
  logic             misr_clr;
  logic             misr_en;
  logic             running;
  logic             bist_end;
  logic             bist_pass;
  logic [CNT_W-1:0] pattern_cnt;

  modport master (
    output start, sig,
`ifdef BIST_ABORT_EN
    output abort,
`endif
    input  lfsr_load, lfsr_en, misr_clr, misr_en, running, bist_end, bist_pass, pattern_cnt
  );

  modport slave (
    input  start, sig,
`ifdef BIST_ABORT_EN
    input  abort,
`endif
    output lfsr_load, lfsr_en, misr_clr, misr_en, running, bist_end, bist_pass, pattern_cnt
  );
endinterface

// File: rtl/bist_sequencer.sv
// BIST sequencer: seed load, pattern run, pipeline flush, signature compare, pass/fail report.
// Optional BIST_ABORT_EN adds an abort input that jumps any active run straight to DONE.
module bist_sequencer #(
  parameter int unsigned      N_PATTERNS = 200,
  parameter int unsigned      CNT_W      = 8,
  parameter int unsigned      SETTLE     = 2,
  parameter int unsigned      SIG_W      = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'hA5C3
) (
  input logic   clk,
  input logic   reset,
  bist_if.slave bus
);

  localparam int unsigned      FL_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned      FL_LAST  = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q, state_nxt;
  logic             start_q;
  logic             edge_c;
  logic             abort_c;
  logic [CNT_W-1:0] cnt_q;
  logic [FL_W-1:0]  fl_q;
  logic             pass_q;
  logic             lfsr_load_q, lfsr_en_q, misr_clr_q, misr_en_q, running_q, end_q;
  logic             lfsr_load_d, lfsr_en_d, misr_clr_d, misr_en_d, running_d, end_d;

  assign edge_c = bus.start & ~start_q;

`ifdef BIST_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // State register plus Moore strobes registered from the next state (same timing as decoding state_q)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      lfsr_load_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      misr_clr_q  <= 1'b0;
      misr_en_q   <= 1'b0;
      running_q   <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      start_q     <= bus.start;
      lfsr_load_q <= lfsr_load_d;
      lfsr_en_q   <= lfsr_en_d;
      misr_clr_q  <= misr_clr_d;
      misr_en_q   <= misr_en_d;
      running_q   <= running_d;
      end_q       <= end_d;
    end
  end

  // Next-state logic and strobe decode of the next state
  always_comb begin
    state_nxt   = state_q;
    lfsr_load_d = 1'b0;
    lfsr_en_d   = 1'b0;
    misr_clr_d  = 1'b0;
    misr_en_d   = 1'b0;
    running_d   = 1'b0;
    end_d       = 1'b0;

    case (state_q)
      S_IDLE:    if (edge_c) state_nxt = S_INIT;
      S_INIT:    state_nxt = S_RUN;
      S_RUN:     if (cnt_q == CNT_LAST) state_nxt = (SETTLE == 0) ? S_COMPARE : S_FLUSH;
      S_FLUSH:   if (fl_q == FL_W'(FL_LAST)) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_DONE;
      S_DONE:    if (edge_c) state_nxt = S_INIT;
      default:   state_nxt = S_IDLE;
    endcase

    if (abort_c && (state_q inside {S_INIT, S_RUN, S_FLUSH, S_COMPARE}))
      state_nxt = S_DONE;

    case (state_nxt)
      S_INIT:    begin lfsr_load_d = 1'b1; misr_clr_d = 1'b1; running_d = 1'b1; end
      S_RUN:     begin lfsr_en_d = 1'b1; misr_en_d = 1'b1; running_d = 1'b1; end
      S_FLUSH:   begin misr_en_d = 1'b1; running_d = 1'b1; end
      S_COMPARE: running_d = 1'b1;
      S_DONE:    end_d = 1'b1;
      default:   ;
    endcase
  end

  // Pattern count, flush count and verdict; an aborting RUN cycle still counts its applied pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      fl_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      fl_q <= (state_q == S_FLUSH) ? fl_q + FL_W'(1) : '0;
      case (state_q)
        S_INIT: begin
          cnt_q  <= '0;
          pass_q <= 1'b0;
        end
        S_RUN:     if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        S_COMPARE: pass_q <= (bus.sig == GOLDEN_SIG) && !abort_c;
        default:   ;
      endcase
      if (abort_c && (state_q inside {S_INIT, S_RUN, S_FLUSH, S_COMPARE}))
        pass_q <= 1'b0;
    end
  end

  assign bus.lfsr_load   = lfsr_load_q;
  assign bus.lfsr_en     = lfsr_en_q;
  assign bus.misr_clr    = misr_clr_q;
  assign bus.misr_en     = misr_en_q;
  assign bus.running     = running_q;
  assign bus.bist_end    = end_q;
  assign bus.bist_pass   = pass_q;
  assign bus.pattern_cnt = cnt_q;

endmodule
